// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-style core: datapath width,
// reset vector, opcode/funct encodings and instruction-word builders.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct codes, instr[5:0]
    localparam logic [5:0] ADD = 6'h20;
    localparam logic [5:0] SUB = 6'h22;
    localparam logic [5:0] AND = 6'h24;
    localparam logic [5:0] OR  = 6'h25;
    localparam logic [5:0] SLT = 6'h2A;

    // Register numbers used by the boot program
    localparam logic [4:0] R_ZERO = 5'd0;
    localparam logic [4:0] R_T0   = 5'd8;
    localparam logic [4:0] R_T1   = 5'd9;
    localparam logic [4:0] R_T2   = 5'd10;
    localparam logic [4:0] R_T3   = 5'd11;
    localparam logic [4:0] R_T4   = 5'd12;
    localparam logic [4:0] R_T5   = 5'd13;
    localparam logic [4:0] R_T6   = 5'd14;
    localparam logic [4:0] R_T7   = 5'd15;

    function automatic logic [XLEN-1:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [XLEN-1:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [XLEN-1:0] enc_j(input logic [25:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/imem.sv
// Read-only instruction memory with asynchronous, zero-latency read.
// Ports:
//   addr        - word index (word i at addr = i), full 32 bits
//   instruction - ROM word at addr; NOP for any addr >= DEPTH (no wrap)
module imem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] instruction
);

    // Boot program; every word from 10 upward reads as zero.
    function automatic logic [XLEN-1:0] rom_word(input logic [XLEN-1:0] idx);
        case (idx)
            32'd0:   return enc_i(OP_ADDI, R_ZERO, R_T0, 16'd5);  // addi $t0,$zero,5
            32'd1:   return enc_i(OP_ADDI, R_ZERO, R_T1, 16'd3);  // addi $t1,$zero,3
            32'd2:   return enc_r(R_T0, R_T1, R_T2, ADD);         // add  $t2,$t0,$t1
            32'd3:   return enc_r(R_T0, R_T1, R_T3, SUB);         // sub  $t3,$t0,$t1
            32'd4:   return enc_r(R_T0, R_T1, R_T4, AND);         // and  $t4,$t0,$t1
            32'd5:   return enc_r(R_T0, R_T1, R_T5, OR);          // or   $t5,$t0,$t1
            32'd6:   return enc_r(R_T1, R_T0, R_T6, SLT);         // slt  $t6,$t1,$t0
            32'd7:   return enc_i(OP_SW, R_ZERO, R_T2, 16'd0);    // sw   $t2,0($zero)
            32'd8:   return enc_i(OP_LW, R_ZERO, R_T7, 16'd0);    // lw   $t7,0($zero)
            32'd9:   return enc_j(26'd0);                         // j    0
            default: return NOP;
        endcase
    endfunction

    always_comb begin
        instruction = NOP;
        if (addr < DEPTH) begin
            instruction = rom_word(addr);
        end
    end

endmodule

// File: rtl/pc.sv
// Program counter register.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset, loads RESET_PC
//   next_pc    - value loaded every edge when not in reset (no enable, no masking)
//   current_pc - registered program counter
module pc
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] current_pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            current_pc <= RESET_PC;
        end else begin
            current_pc <= next_pc;
        end
    end

endmodule

// File: rtl/pc_imem.sv
// Instruction-fetch front end: PC register feeding the instruction ROM.
// Ports:
//   clk         - rising-edge clock, sole domain
//   reset       - synchronous active-high reset (PC <= RESET_PC)
//   next_pc     - externally computed next PC, loaded every edge
//   current_pc  - registered program counter
//   instruction - IMEM word at current_pc[31:2]; byte offset bits ignored
module pc_imem
    import cpu_pkg::*;
#(
    parameter int unsigned     DEPTH    = 256,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] instruction
);

    logic [XLEN-1:0] word_addr;

    // Byte address to word index; the two offset bits are dropped.
    assign word_addr = {2'b00, current_pc[XLEN-1:2]};

    pc #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .next_pc   (next_pc),
        .current_pc(current_pc)
    );

    imem #(
        .DEPTH(DEPTH)
    ) u_imem (
        .addr       (word_addr),
        .instruction(instruction)
    );

endmodule

// File: tb/tb_pc_imem.sv
module tb_pc_imem;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic [31:0] current_pc;
    logic [31:0] instruction;

    // Standalone sub-module instances
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic        p_reset;
    logic [31:0] p_next;
    logic [31:0] p_cur;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_imem #(.DEPTH(256), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .current_pc (current_pc),
        .instruction(instruction)
    );

    imem #(.DEPTH(256)) u_imem_sa (
        .addr       (m_addr),
        .instruction(m_instr)
    );

    pc #(.RESET_PC(32'h0000_0100)) u_pc_sa (
        .clk       (clk),
        .reset     (p_reset),
        .next_pc   (p_next),
        .current_pc(p_cur)
    );

    // Reference program, written as raw hex words.
    logic [31:0] prog [10] = '{
        32'h20080005, 32'h20090003, 32'h01095020, 32'h01095822, 32'h01096024,
        32'h01096825, 32'h0128702A, 32'hAC0A0000, 32'h8C0F0000, 32'h08000000
    };

    function automatic logic [31:0] ref_fetch(input logic [31:0] byte_addr);
        longint unsigned w;
        w = longint'(byte_addr) / 4;
        if (w < 10) return prog[w];
        return 32'h0;   // words 10..255 are zero and >= 256 is out of range
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] npc;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [$];
    logic [31:0] model_pc;
    logic [31:0] w;

    initial begin
        reset   = 1'b1;
        next_pc = 32'h1234;
        m_addr  = '0;
        p_reset = 1'b1;
        p_next  = 32'hDEAD_BEEF;

        // reset, sequential fetch, mid-run reset, out-of-range, misaligned load
        vecs.push_back('{1'b1, 32'h0000_1234, 32'h0000_0000, 32'h20080005});
        vecs.push_back('{1'b1, 32'h0000_1234, 32'h0000_0000, 32'h20080005});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0000_0004, 32'h20090003});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0000_0008, 32'h01095020});
        vecs.push_back('{1'b0, 32'h0000_000C, 32'h0000_000C, 32'h01095822});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0010, 32'h01096024});
        vecs.push_back('{1'b0, 32'h0000_0014, 32'h0000_0014, 32'h01096825});
        vecs.push_back('{1'b0, 32'h0000_0018, 32'h0000_0018, 32'h0128702A});
        vecs.push_back('{1'b1, 32'h0000_001C, 32'h0000_0000, 32'h20080005});
        vecs.push_back('{1'b0, 32'h0000_001C, 32'h0000_001C, 32'hAC0A0000});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0020, 32'h8C0F0000});
        vecs.push_back('{1'b0, 32'h0000_0024, 32'h0000_0024, 32'h08000000});
        vecs.push_back('{1'b0, 32'h0000_0028, 32'h0000_0028, 32'h00000000});
        vecs.push_back('{1'b0, 32'h0000_0400, 32'h0000_0400, 32'h00000000});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h00000000});
        vecs.push_back('{1'b0, 32'h0000_0026, 32'h0000_0026, 32'h08000000});
        vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0000_03FC, 32'h00000000});
        vecs.push_back('{1'b0, 32'h0000_0005, 32'h0000_0005, 32'h20090003});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h20080005});

        foreach (vecs[i]) begin
            reset   = vecs[i].rst;
            next_pc = vecs[i].npc;
            step();
            check($sformatf("vec%0d pc", i), current_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d instr", i), instruction, vecs[i].exp_instr);
        end

        // Standalone pc with a non-zero reset vector (held in reset so far)
        check("pc_sa reset", p_cur, 32'h0000_0100);
        p_reset = 1'b0;
        p_next  = 32'hDEAD_BEEF;
        step();
        check("pc_sa load", p_cur, 32'hDEAD_BEEF);
        p_next  = 32'h0000_0003;
        step();
        check("pc_sa unaligned", p_cur, 32'h0000_0003);
        p_reset = 1'b1;
        p_next  = 32'h5555_AAAA;
        step();
        check("pc_sa reset prio", p_cur, 32'h0000_0100);

        // Standalone imem sweep and boundaries
        for (int unsigned a = 0; a < 10; a++) begin
            m_addr = a;
            #1;
            check($sformatf("imem addr %0d", a), m_instr, prog[a]);
        end
        m_addr = 32'd2;
        #1;
        w = m_instr;
        check("addr2 opcode", {26'd0, w[31:26]}, 32'd0);
        check("addr2 rs",     {27'd0, w[25:21]}, 32'd8);
        check("addr2 rt",     {27'd0, w[20:16]}, 32'd9);
        check("addr2 rd",     {27'd0, w[15:11]}, 32'd10);
        check("addr2 shamt",  {27'd0, w[10:6]},  32'd0);
        check("addr2 funct",  {26'd0, w[5:0]},   32'h20);
        m_addr = 32'd10;
        #1;
        check("imem addr 10", m_instr, 32'h0);
        m_addr = 32'd255;
        #1;
        check("imem addr 255", m_instr, 32'h0);
        m_addr = 32'd256;
        #1;
        check("imem addr DEPTH", m_instr, 32'h0);
        m_addr = 32'hFFFF_FFFF;
        #1;
        check("imem addr max", m_instr, 32'h0);

        // Randomized run against the behavioural model
        reset   = 1'b1;
        next_pc = $urandom;
        step();
        model_pc = 32'h0;
        check("rand reset pc", current_pc, model_pc);
        for (int n = 0; n < 300; n++) begin
            reset = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       next_pc = $urandom;
                1:       next_pc = $urandom_range(0, 63);
                default: next_pc = $urandom_range(0, 300) * 4;
            endcase
            model_pc = reset ? 32'h0 : next_pc;
            step();
            check($sformatf("rand%0d pc", n), current_pc, model_pc);
            check($sformatf("rand%0d instr", n), instruction, ref_fetch(model_pc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
